// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants and types for the UART blocks.
//   UART_DATA_W    : payload width of one UART character
//   RX_FIFO_ADDR_W : pointer width of the receive FIFO (depth 2**ADDR_W)
//   RX_FIFO_AFULL  : receive FIFO fill level at which almost-full asserts
//   rx_entry_t     : one receive FIFO entry, {frame_err, data}
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int RX_FIFO_ADDR_W = 4;
    localparam int RX_FIFO_AFULL  = 12;

    typedef struct packed {
        logic                   frame_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/fifo_rx_memory.sv
// fifo_rx_memory
// Storage array for the receive FIFO: 2**ADDR_W entries of DATA_W+1 bits,
// one synchronous write port and one asynchronous read port. Not reset;
// the FIFO only ever reads slots it has written since the last reset.
// Ports:
//   clk     : clock for the write port
//   wr_en   : write strobe
//   wr_addr : write slot
//   wr_data : entry to store
//   rd_addr : read slot
//   rd_data : entry at rd_addr (combinational)
module fifo_rx_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W:0]   rd_data
);

    logic [DATA_W:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_rx.sv
// fifo_rx
// Receive-side first-word-fall-through FIFO between the UART receiver and
// the host. Each entry is a received byte plus its framing-error flag.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   rx_valid      : receiver strobe, qualifies rx_data / rx_frame_err
//   rx_data       : received byte
//   rx_frame_err  : stop-bit error for the received byte
//   rd_en         : pop the head entry (ignored while empty)
//   ovr_clr       : clear the sticky overrun flag
//   data_out      : head byte, 0 while empty
//   frame_err_out : head framing flag, 0 while empty
//   fifo_empty, fifo_full, fifo_afull : status decoded from fill_level
//   fill_level    : number of stored entries (0 .. 2**ADDR_W)
//   overrun       : sticky, a byte arrived while full and was dropped
module fifo_rx
    import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int ADDR_W    = RX_FIFO_ADDR_W,
    parameter int AFULL_LVL = RX_FIFO_AFULL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_frame_err,
    input  logic              rd_en,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_err_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_afull,
    output logic [ADDR_W:0]   fill_level,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_accept;
    logic              rd_accept;
    logic              ovr_event;
    logic [DATA_W:0]   head_entry;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts
    // a byte when rd_en is high; the write lands in the slot being read.
    assign wr_accept = rx_valid && (!fifo_full || rd_en);
    assign rd_accept = rd_en && !fifo_empty;
    assign ovr_event = rx_valid && fifo_full && !rd_en;

    fifo_rx_memory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_memory (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data ({rx_frame_err, rx_data}),
        .rd_addr (rd_ptr),
        .rd_data (head_entry)
    );

    // Pointers wrap naturally; occupancy comes only from fill_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_accept && !rd_accept) begin
                fill_level <= fill_level + ONE_CNT;
            end else if (rd_accept && !wr_accept) begin
                fill_level <= fill_level - ONE_CNT;
            end
        end
    end

    // Sticky overrun: a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_event) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    assign fifo_empty = (fill_level == '0);
    assign fifo_full  = (fill_level == FULL_CNT);
    assign fifo_afull = (fill_level >= AFULL_CNT);

    // Memory is not reset, so the head is masked while nothing is stored.
    assign data_out      = fifo_empty ? '0   : head_entry[DATA_W-1:0];
    assign frame_err_out = fifo_empty ? 1'b0 : head_entry[DATA_W];

endmodule

// File: tb/tb_fifo_rx.sv
// tb_fifo_rx
// Self-checking bench for fifo_rx. The driver pushes each accepted byte
// into a scoreboard queue; a monitor pops and compares whenever a pop is
// presented to the DUT. Status outputs are compared against a small model.
module tb_fifo_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rd_en;
    logic       ovr_clr;
    logic [7:0] data_out;
    logic       frame_err_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_afull;
    logic [4:0] fill_level;
    logic       overrun;

    int        tests_run    = 0;
    int        tests_failed = 0;
    rx_entry_t exp_q[$];
    int        m_fill;
    logic      m_ovr;

    fifo_rx dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_frame_err  (rx_frame_err),
        .rd_en         (rd_en),
        .ovr_clr       (ovr_clr),
        .data_out      (data_out),
        .frame_err_out (frame_err_out),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .fifo_afull    (fifo_afull),
        .fill_level    (fill_level),
        .overrun       (overrun)
    );

    initial forever #5 clk = ~clk;

    // Single comparison; every check in the bench goes through here.
    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, update the model at the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic fe,
                                 input logic rd, input logic clr);
        logic wr_ok;
        logic rd_ok;
        logic ovr;
        rx_entry_t e;
        rx_valid     = v;
        rx_data      = d;
        rx_frame_err = fe;
        rd_en        = rd;
        ovr_clr      = clr;
        wr_ok = v && ((m_fill < 16) || rd);
        rd_ok = rd && (m_fill > 0);
        ovr   = v && (m_fill == 16) && !rd;
        @(posedge clk);
        if (wr_ok) begin
            e.frame_err = fe;
            e.data      = d;
            exp_q.push_back(e);
        end
        m_fill = m_fill + int'(wr_ok) - int'(rd_ok);
        if (ovr)      m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        #1;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        ovr_clr  = 1'b0;
    endtask

    // Compare all status outputs and the fall-through head with the model.
    task automatic checkOutput(input string tag);
        logic [7:0] hd;
        logic       hf;
        hd = 8'h00;
        hf = 1'b0;
        if (exp_q.size() > 0) begin
            hd = exp_q[0].data;
            hf = exp_q[0].frame_err;
        end
        check1({tag, "/fill"},  32'(fill_level),  32'(m_fill));
        check1({tag, "/empty"}, 32'(fifo_empty),  32'(m_fill == 0));
        check1({tag, "/full"},  32'(fifo_full),   32'(m_fill == 16));
        check1({tag, "/afull"}, 32'(fifo_afull),  32'(m_fill >= 12));
        check1({tag, "/ovr"},   32'(overrun),     32'(m_ovr));
        check1({tag, "/head"},  32'(data_out),    32'(hd));
        check1({tag, "/hferr"}, 32'(frame_err_out), 32'(hf));
    endtask

    // Monitor: on every presented pop, the head must match the scoreboard.
    always @(negedge clk) begin : monitor
        rx_entry_t e;
        if (!rst && rd_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check1("pop_data", 32'(data_out), 32'(e.data));
                check1("pop_ferr", 32'(frame_err_out), 32'(e.frame_err));
            end else begin
                check1("pop_when_empty", 32'(fifo_empty), 32'd1);
                check1("pop_when_empty_data", 32'(data_out), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
        rx_frame_err = 1'b0;
        rd_en        = 1'b0;
        ovr_clr      = 1'b0;
        m_fill       = 0;
        m_ovr        = 1'b0;
        #1;
        checkOutput("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Single byte falls through, then pops out.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_a5");
        check1("a5_head", 32'(data_out), 32'h A5);
        check1("a5_fill", 32'(fill_level), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("pop_a5");
        check1("a5_empty", 32'(fifo_empty), 32'd1);

        // Three fill/drain passes to cover pointer wrap.
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < 16; i++) begin
                applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
                checkOutput("fill");
            end
            check1("full_at_16", 32'(fifo_full), 32'd1);
            check1("afull_at_16", 32'(fifo_afull), 32'd1);
            for (int i = 0; i < 16; i++) begin
                applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
                checkOutput("drain");
            end
            check1("drained_empty", 32'(fifo_empty), 32'd1);
        end

        // Overrun while full, set-wins-over-clear, then clear.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("full_again");
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun");
        check1("ovr_set", 32'(overrun), 32'd1);
        check1("ovr_fill", 32'(fill_level), 32'd16);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        check1("ovr_set_wins", 32'(overrun), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovr_clr");
        check1("ovr_cleared", 32'(overrun), 32'd0);

        // Write with simultaneous pop while full.
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("full_wr_rd");
        check1("wr_rd_fill", 32'(fill_level), 32'd16);
        check1("wr_rd_head", 32'(data_out), 32'h11);
        check1("wr_rd_ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            checkOutput("drain2");
        end

        // Framing flag travels with its byte.
        applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check1("ferr_head_1", 32'(frame_err_out), 32'd1);
        applyStimulus(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check1("ferr_head_0", 32'(frame_err_out), 32'd0);
        check1("ferr_data_3d", 32'(data_out), 32'h3D);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("ferr_done");

        // Asynchronous reset with five entries stored.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("five");
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        m_fill = 0;
        m_ovr  = 1'b0;
        checkOutput("async_rst");
        check1("rst_data", 32'(data_out), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Pop while empty is a no-op; write+pop while empty is a write.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("rd_empty");
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
        checkOutput("wr_rd_empty");
        check1("wr_rd_empty_head", 32'(data_out), 32'h5A);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_rx.md
# fifo_rx

Receive-side buffer for the UART: a 16-entry first-word-fall-through FIFO between the UART receiver and the consumer. Each entry holds one received byte and its framing-error flag. The block mirrors the transmit FIFO: there the host writes and the line side reads; here the line side writes and the host reads. It reports fill level, almost-full, and a sticky overrun flag for dropped bytes.

## Interface
- `DATA_W`, 8, payload width per entry; each stored entry is `DATA_W+1` bits wide.
- `ADDR_W`, 4, pointer width; depth is `2**ADDR_W` (16).
- `AFULL_LVL`, 12, fill level at or above which `fifo_afull` asserts.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe from the UART receiver: a byte is complete.
- `rx_data`  in  DATA_W  received byte, qualified by `rx_valid`.
- `rx_frame_err`  in  1  stop-bit error for this byte, qualified by `rx_valid`.
- `rd_en`  in  1  pop the head entry. Ignored while empty.
- `ovr_clr`  in  1  clears the sticky overrun flag.
- `data_out`  out  DATA_W  head byte; 0 while empty.
- `frame_err_out`  out  1  framing flag of the head entry; 0 while empty.
- `fifo_empty`  out  1  no entries stored.
- `fifo_full`  out  1  `2**ADDR_W` entries stored.
- `fifo_afull`  out  1  `fill_level >= AFULL_LVL`.
- `fill_level`  out  ADDR_W+1  number of stored entries, 0 to 16.
- `overrun`  out  1  sticky flag: a byte was dropped.

## Operation
- Storage is 16 × 9 bits: a synchronous write port and an asynchronous read port addressed by `rd_ptr`.
- `wr_ptr` and `rd_ptr` are `ADDR_W` bits and wrap naturally from 15 to 0.
- `fill_level` is a separate `ADDR_W+1`-bit counter. `fifo_full`, `fifo_empty` and `fifo_afull` are all decoded from this counter, not from pointer comparison.
- Write is accepted when `rx_valid && (!fifo_full || rd_en)`. On accept: store `{rx_frame_err, rx_data}` at `wr_ptr`, then increment `wr_ptr`.
- Read is accepted when `rd_en && !fifo_empty`. On accept: increment `rd_ptr`.
- `fill_level` update per edge:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Overrun occurs on `rx_valid && fifo_full && !rd_en`.
  - The byte is dropped and FIFO contents are unchanged.
  - `overrun` is set on the next edge and holds until `ovr_clr`.
  - If an overrun and `ovr_clr` occur in the same cycle, set wins.
- `rd_en` while empty is a no-op with no error flag. `rx_valid` and `rd_en` while empty gives a write only; the new byte appears at the head next cycle.
- State is implied by `fill_level`: EMPTY (0), PARTIAL (1–15), FULL (16). All transitions are ±1 per cycle.

## Timing
- Reset values (asynchronous): pointers 0, `fill_level` 0, `fifo_empty` 1, `fifo_full` 0, `fifo_afull` 0, `overrun` 0, `data_out` 0, `frame_err_out` 0.
- Memory contents are not reset.
- Write latency: a byte strobed at edge N is on `data_out` and `fifo_empty` is low after edge N. First-word fall-through; combinational read from registered pointer.
- Pop: `data_out` shows the next entry after the edge where `rd_en` is sampled.
- All flags are registered or decoded from registered `fill_level`. They change only on `clk` edges or on `rst`.
- Reset asserted mid-stream empties the FIFO immediately. Any partially buffered data is lost.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8.
  - `RX_FIFO_ADDR_W` = 4.
  - `RX_FIFO_AFULL` = 12.
  - Entry typedef `rx_entry_t` = `{frame_err, data[7:0]}`.
- One sub-module, `fifo_rx_memory`: a 16 × `DATA_W+1` register array with write enable, write address, read address and asynchronous read. It has no reset.
- Pointer, counter and flag logic live in `fifo_rx`.

## Test plan
- Reset, then write 0xA5 with `frame_err=0` → next cycle `data_out`=0xA5, `fifo_empty`=0, `fill_level`=1. Pop → `fifo_empty`=1, `data_out`=0.
- Write 16 bytes 0x00–0x0F → `fifo_afull` rises as `fill_level` reaches 12 and `fifo_full`=1 at 16. Then 16 pops → bytes return in order and `fifo_empty`=1; repeat twice to cover pointer wrap.
- When full, strobe 0xEE with `rd_en`=0 → `overrun`=1, `fill_level` stays 16, 0xEE never appears. Pulse `ovr_clr` → `overrun`=0.
- When full, strobe 0x77 with `rd_en`=1 → head advances, `fill_level` stays 16, `overrun` stays 0, and 0x77 is read out last.
- Write 0x3C with `frame_err=1`, then 0x3D with `frame_err=0` → `frame_err_out` reads 1 then 0 on the corresponding pops.
- Assert `rst` asynchronously with 5 entries stored → all outputs at reset values before the next `clk` edge. `rd_en` while empty → no change.
